// File: rtl/uart_programmer.sv
// Boot loader: 8N1 UART receiver feeding a segment-framed parser that writes
// 32-bit words into instruction ROM (adr[14]=0) or data RAM (adr[14]=1).
module uart_programmer #(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic        upg_clk_i,
    input  logic        upg_rstn_i,
    input  logic        upg_rx_i,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_err_o
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [2:0] {P_HDR, P_CNT_LO, P_CNT_HI, P_DATA, P_DONE} p_state_e;

    logic            sync1_q, sync2_q, rx_prev_q;
    rx_state_e       rx_state_q, rx_state_d;
    logic [CW-1:0]   tick_q, tick_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tick_end, half_end, byte_vld, frame_err;

    p_state_e        p_state_q, p_state_d;
    logic            last_q, last_d;
    logic [7:0]      cnt_lo_q, cnt_lo_d;
    logic [13:0]     words_q, words_d;
    logic [1:0]      byte_idx_q, byte_idx_d;
    logic [23:0]     word_q, word_d;
    logic [14:0]     adr_q, adr_d;
    logic [31:0]     dat_q, dat_d;
    logic            wen_q, wen_d, done_q, done_d, err_q, err_d;
    logic [13:0]     cnt_full;

    assign tick_end = (tick_q == BIT_LAST);
    assign half_end = (tick_q == HALF_LAST);
    // Bits [15:14] of the word count are deliberately dropped.
    assign cnt_full = {shift_q[5:0], cnt_lo_q};

    // State registers
    always_ff @(posedge upg_clk_i or negedge upg_rstn_i) begin
        if (!upg_rstn_i) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            tick_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            p_state_q  <= P_HDR;
            last_q     <= 1'b0;
            cnt_lo_q   <= '0;
            words_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            adr_q      <= '0;
            dat_q      <= '0;
            wen_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= upg_rx_i;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            rx_state_q <= rx_state_d;
            tick_q     <= tick_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            p_state_q  <= p_state_d;
            last_q     <= last_d;
            cnt_lo_q   <= cnt_lo_d;
            words_q    <= words_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            wen_q      <= wen_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic for both FSMs
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (rx_prev_q && !sync2_q) rx_state_d = RX_START;
            RX_START: if (half_end) rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick_end && bit_idx_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (tick_end) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase

        p_state_d = p_state_q;
        if (byte_vld) begin
            case (p_state_q)
                P_HDR:    p_state_d = P_CNT_LO;
                P_CNT_LO: p_state_d = P_CNT_HI;
                P_CNT_HI: begin
                    if (cnt_full == 14'd0) p_state_d = last_q ? P_DONE : P_HDR;
                    else                   p_state_d = P_DATA;
                end
                P_DATA: begin
                    if (byte_idx_q == 2'd3 && words_q == 14'd1)
                        p_state_d = last_q ? P_DONE : P_HDR;
                end
                default:  p_state_d = p_state_q;
            endcase
        end
    end

    // Output / datapath logic
    always_comb begin
        tick_d     = tick_q + CW'(1);
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        byte_vld   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RX_IDLE:  tick_d = '0;
            RX_START: if (half_end) begin
                tick_d    = '0;
                bit_idx_d = '0;
            end
            RX_DATA:  if (tick_end) begin
                tick_d    = '0;
                shift_d   = {sync2_q, shift_q[7:1]};
                bit_idx_d = bit_idx_q + 3'd1;
            end
            RX_STOP:  if (tick_end) begin
                tick_d    = '0;
                byte_vld  = sync2_q;
                frame_err = !sync2_q;
            end
            default:  tick_d = '0;
        endcase

        last_d     = last_q;
        cnt_lo_d   = cnt_lo_q;
        words_d    = words_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        wen_d      = 1'b0;
        // Done lags DONE-state entry by a cycle so it follows the final strobe.
        done_d     = done_q | (p_state_q == P_DONE);
        err_d      = err_q | frame_err;
        if (wen_q) adr_d[13:0] = adr_q[13:0] + 14'd1;
        if (byte_vld) begin
            case (p_state_q)
                P_HDR: begin
                    last_d = shift_q[7];
                    adr_d  = {shift_q[0], 14'd0};
                end
                P_CNT_LO: cnt_lo_d = shift_q;
                P_CNT_HI: begin
                    words_d    = cnt_full;
                    byte_idx_d = 2'd0;
                    if (cnt_full == 14'd0 && last_q) done_d = 1'b1;
                end
                P_DATA: begin
                    byte_idx_d = byte_idx_q + 2'd1;
                    case (byte_idx_q)
                        2'd0:    word_d[7:0]   = shift_q;
                        2'd1:    word_d[15:8]  = shift_q;
                        2'd2:    word_d[23:16] = shift_q;
                        default: begin
                            dat_d   = {shift_q, word_q};
                            wen_d   = 1'b1;
                            words_d = words_q - 14'd1;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign upg_err_o  = err_q;
endmodule

// File: tb/tb_uart_programmer.sv
// Self-checking bench for uart_programmer: vector table, hand-written line
// corner cases, and random segment streams checked against a parsing model.
module tb_uart_programmer;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        rx;
    logic        wen, done, err;
    logic [14:0] adr;
    logic [31:0] dat;

    uart_programmer #(.CLKS_PER_BIT(CPB)) dut (
        .upg_clk_i (clk),
        .upg_rstn_i(rstn),
        .upg_rx_i  (rx),
        .upg_wen_o (wen),
        .upg_adr_o (adr),
        .upg_dat_o (dat),
        .upg_done_o(done),
        .upg_err_o (err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int done_cyc = -1;
    logic done_prev = 1'b0;

    logic [14:0] wr_adr[$];
    logic [31:0] wr_dat[$];
    int          wr_cyc[$];
    logic [14:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_done;
    logic [7:0]  stim[$];

    typedef struct {
        int           nb;
        logic [127:0] b;    // first byte in [127:120]
        int           nwr;
        logic [14:0]  a0;
        logic [31:0]  d0;
        logic [14:0]  a1;
        logic [31:0]  d1;
        logic         dn;
    } vec_t;
    vec_t vecs[4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rstn) begin
            if (wen) begin
                wr_adr.push_back(adr);
                wr_dat.push_back(dat);
                wr_cyc.push_back(cyc);
            end
            if (done && !done_prev) done_cyc = cyc;
        end
        done_prev = done;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_log();
        wr_adr.delete();
        wr_dat.delete();
        wr_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(negedge clk);
        clear_log();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Called at a negedge; returns at a negedge with the line idle.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_list(input logic [127:0] b, input int nb);
        for (int i = 0; i < nb; i++) send_byte(b[127-8*i -: 8], 1'b1);
    endtask

    // Reference: walk the byte stream segment by segment.
    task automatic model();
        int i, n;
        logic [7:0]  hdr;
        logic [14:0] a;
        exp_adr.delete();
        exp_dat.delete();
        exp_done = 1'b0;
        i = 0;
        while (i + 3 <= stim.size() && !exp_done) begin
            hdr = stim[i];
            n   = int'({stim[i+2][5:0], stim[i+1]});
            i  += 3;
            a   = {hdr[0], 14'd0};
            for (int w = 0; w < n && i + 4 <= stim.size(); w++) begin
                exp_adr.push_back(a);
                exp_dat.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
                a[13:0] = a[13:0] + 14'd1;
                i += 4;
            end
            if (hdr[7]) exp_done = 1'b1;
        end
    endtask

    initial begin
        rstn = 1'b0;
        rx   = 1'b1;

        vecs[0] = '{11, {8'h80, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                         8'hEF, 8'hBE, 8'hAD, 8'hDE, 40'h0},
                    2, 15'h0000, 32'h12345678, 15'h0001, 32'hDEADBEEF, 1'b1};
        vecs[1] = '{14, {8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                         8'h81, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 16'h0},
                    2, 15'h0000, 32'h00000001, 15'h4000, 32'hAABBCCDD, 1'b1};
        vecs[2] = '{3, {8'h80, 8'h00, 8'h00, 104'h0},
                    0, 15'h0, 32'h0, 15'h0, 32'h0, 1'b1};
        vecs[3] = '{7, {8'h81, 8'h01, 8'hC0, 8'h11, 8'h22, 8'h33, 8'h44, 72'h0},
                    1, 15'h4000, 32'h44332211, 15'h4000, 32'h44332211, 1'b1};

        do_reset();
        chk("rst_wen", wen, 0);
        chk("rst_adr", adr, 0);
        chk("rst_dat", dat, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            send_list(vecs[v].b, vecs[v].nb - 1);
            chk($sformatf("v%0d_early_done", v), done, 0);
            send_byte(vecs[v].b[127-8*(vecs[v].nb-1) -: 8], 1'b1);
            repeat (10) @(negedge clk);
            chk($sformatf("v%0d_nwr", v), wr_adr.size(), vecs[v].nwr);
            if (vecs[v].nwr > 0 && wr_adr.size() == vecs[v].nwr) begin
                chk($sformatf("v%0d_adr0", v), wr_adr[0], vecs[v].a0);
                chk($sformatf("v%0d_dat0", v), wr_dat[0], vecs[v].d0);
                chk($sformatf("v%0d_adrN", v), wr_adr[vecs[v].nwr-1], vecs[v].a1);
                chk($sformatf("v%0d_datN", v), wr_dat[vecs[v].nwr-1], vecs[v].d1);
                chk($sformatf("v%0d_done_lag", v), done_cyc - wr_cyc[vecs[v].nwr-1], 1);
            end
            chk($sformatf("v%0d_done", v), done, vecs[v].dn);
        end

        // One-cycle low glitch must not produce a byte
        do_reset();
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_err", err, 0);
        send_list({8'h80, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 72'h0}, 7);
        repeat (10) @(negedge clk);
        chk("glitch_nwr", wr_adr.size(), 1);
        if (wr_adr.size() == 1) begin
            chk("glitch_adr", wr_adr[0], 15'h0000);
            chk("glitch_dat", wr_dat[0], 32'h04030201);
        end

        // Framing error: byte dropped, sticky error, next frame intact
        do_reset();
        send_byte(8'h55, 1'b0);
        repeat (8) @(negedge clk);
        chk("ferr_err", err, 1);
        chk("ferr_nwr0", wr_adr.size(), 0);
        send_list({8'h80, 8'h01, 8'h00, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 72'h0}, 7);
        repeat (10) @(negedge clk);
        chk("ferr_nwr", wr_adr.size(), 1);
        if (wr_adr.size() == 1) begin
            chk("ferr_adr", wr_adr[0], 15'h0000);
            chk("ferr_dat", wr_dat[0], 32'hAABBCCDD);
        end
        chk("ferr_done", done, 1);

        // Asynchronous reset in the middle of the second word
        do_reset();
        send_list({8'h80, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 56'h0}, 9);
        repeat (2) @(negedge clk);
        chk("mid_pre_adr", adr, 15'h0001);
        chk("mid_pre_dat", dat, 32'h44332211);
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_adr", adr, 0);
        chk("mid_rst_dat", dat, 0);
        chk("mid_rst_wen", wen, 0);
        chk("mid_rst_done", done, 0);
        repeat (2) @(negedge clk);
        clear_log();
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        send_list({8'h80, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 72'h0}, 7);
        repeat (10) @(negedge clk);
        chk("mid_nwr", wr_adr.size(), 1);
        if (wr_adr.size() == 1) begin
            chk("mid_adr", wr_adr[0], 15'h0000);
            chk("mid_dat", wr_dat[0], 32'hD4C3B2A1);
        end

        // Traffic after done is ignored, but framing errors still register
        do_reset();
        send_list(vecs[0].b, vecs[0].nb);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
        send_byte(8'h3C, 1'b0);
        repeat (10) @(negedge clk);
        chk("post_nwr", wr_adr.size(), 2);
        chk("post_adr", adr, 15'h0002);
        chk("post_dat", dat, 32'hDEADBEEF);
        chk("post_done", done, 1);
        chk("post_err", err, 1);

        // Random multi-segment streams against the reference model
        for (int it = 0; it < 5; it++) begin
            int nseg, n;
            stim.delete();
            nseg = $urandom_range(1, 3);
            for (int s = 0; s < nseg; s++) begin
                logic [7:0] hdr;
                hdr    = 8'($urandom);
                hdr[7] = (s == nseg - 1) ? 1'($urandom) : 1'b0;
                n      = $urandom_range(0, 3);
                stim.push_back(hdr);
                stim.push_back(8'(n));
                stim.push_back({2'($urandom), 6'd0});
                for (int k = 0; k < 4 * n; k++) stim.push_back(8'($urandom));
            end
            model();
            do_reset();
            foreach (stim[i]) send_byte(stim[i], 1'b1);
            repeat (10) @(negedge clk);
            chk($sformatf("rnd%0d_nwr", it), wr_adr.size(), exp_adr.size());
            if (wr_adr.size() == exp_adr.size()) begin
                foreach (exp_adr[i]) begin
                    chk($sformatf("rnd%0d_adr%0d", it, i), wr_adr[i], exp_adr[i]);
                    chk($sformatf("rnd%0d_dat%0d", it, i), wr_dat[i], exp_dat[i]);
                end
            end
            chk($sformatf("rnd%0d_done", it), done, exp_done);
            chk($sformatf("rnd%0d_err", it), err, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/uart_programmer.md
# uart_programmer

Boot-time loader that drives the UART-programmer write port of the instruction ROM and data RAM. It deserialises 8N1 UART bytes from the host, parses a segment-framed download protocol, and packs the payload into 32-bit words. Each word is presented on `upg_adr_o`/`upg_dat_o` with a one-cycle `upg_wen_o` strobe. `upg_done_o` releases the CPU into normal mode once the final segment has been written. The block runs entirely in the UPG clock domain.

## Interface
- `CLKS_PER_BIT`, default 87: UPG clock cycles per UART bit (10 MHz / 115200). Must be ≥ 4.
- `upg_clk_i`  in  1  UPG clock (10 MHz); the block's only clock.
- `upg_rstn_i`  in  1  reset; asynchronous, active-low.
- `upg_rx_i`  in  1  UART serial line; idles high.
- `upg_wen_o`  out  1  memory write strobe; one cycle per word.
- `upg_adr_o`  out  15  write address. [14]=0 selects instruction ROM, 1 selects data RAM; [13:0] is the word index.
- `upg_dat_o`  out  32  write data word.
- `upg_done_o`  out  1  download finished; sticky until reset.
- `upg_err_o`  out  1  sticky framing-error flag.

## Operation
- **Reset values:** `upg_wen_o`=0, `upg_adr_o`=0, `upg_dat_o`=0, `upg_done_o`=0, `upg_err_o`=0. RX state is IDLE and parser state is HDR.
- **RX sync:** `upg_rx_i` passes through a 2-flop synchroniser; the synchroniser resets to 1.
- **RX FSM:** IDLE → START → DATA → STOP → IDLE.
  - IDLE→START: on a synchronised falling edge.
  - START: the line is sampled after CLKS_PER_BIT/2 cycles. If it is high, the start is treated as a glitch and the FSM returns to IDLE with no byte.
  - DATA: 8 bits, LSB first, sampled every CLKS_PER_BIT cycles at bit centre.
  - STOP: the stop bit is sampled at its centre. High delivers the byte as a one-cycle internal `byte_vld`. Low sets `upg_err_o`, drops the byte, and leaves parser state unchanged.
- **Parser FSM:** HDR → CNT_LO → CNT_HI → DATA → (HDR | DONE).
  - HDR byte: bit0 = target (0 ROM, 1 RAM), bit7 = last segment; other bits are ignored. On a HDR byte, the segment address [13:0] is cleared and [14] is loaded with the target bit.
  - CNT_LO and CNT_HI carry the word count N, little-endian. Only N[13:0] is used; N[15:14] are ignored.
  - N=0 after CNT_HI: no writes. The parser goes to DONE if the last flag is set, otherwise back to HDR.
  - DATA: bytes are packed little-endian; the first byte lands in [7:0]. On the 4th byte, the word is written and the byte counter wraps to 0.
  - After the N-th word, the parser goes to DONE if the last flag is set, otherwise back to HDR.
  - DONE: `upg_done_o`=1. All further RX bytes are ignored, but framing errors still set `upg_err_o`.
- **Address arithmetic:** `upg_adr_o[13:0]` increments by 1 after each write and wraps from 0x3FFF to 0x0000. Bit [14] never changes within a segment.
- **Async reset mid-operation:** all state and outputs return to their reset values immediately. A partially received word is discarded.

## Timing
- Let T be the cycle in which `byte_vld` fires for the 4th byte of a word.
  - `upg_wen_o` is high in cycle T+1 only.
  - `upg_adr_o` and `upg_dat_o` are stable throughout that cycle.
  - `upg_adr_o` increments at the edge that ends the strobe.
- `upg_done_o` rises in the cycle after the final `upg_wen_o` pulse. For N=0, it rises in the cycle after CNT_HI's `byte_vld`.
- Between strobes, `upg_dat_o` holds the last written word.
- Byte throughput is one byte per 10·CLKS_PER_BIT cycles. Back-to-back bytes with no idle time must be accepted: the RX FSM re-arms in IDLE during the second half of the stop bit.
- `byte_vld` and a parser transition in the same cycle never conflict, because the parser consumes `byte_vld` only on that edge.

## Test plan
Benches use CLKS_PER_BIT=4.
- **Single ROM segment:** send 0x80, 0x02, 0x00, 78 56 34 12 EF BE AD DE → two `upg_wen_o` pulses: (adr 0x0000, dat 0x12345678) then (0x0001, 0xDEADBEEF). `upg_done_o` rises the next cycle.
- **Two segments:** send 0x00, count 1, 01 00 00 00, then 0x81, count 1, DD CC BB AA → writes (0x0000, 0x00000001) then (0x4000, 0xAABBCCDD). `upg_done_o`=1 after the second write only.
- **Empty last segment:** send 0x80, 0x00, 0x00 → no `upg_wen_o` pulses; `upg_done_o` rises the cycle after the third byte.
- **Line errors:**
  - Hold rx low for 1 cycle → no byte, parser still in HDR.
  - Send a byte with the stop bit low → `upg_err_o`=1 and the byte is dropped. A following valid frame still loads correctly.
- **Reset mid-word:** assert `upg_rstn_i` low after 2 data bytes → all outputs read 0 immediately. A subsequent full frame writes from adr 0x0000 with no leftover bytes.
- **Post-done traffic:** after `upg_done_o`, send 8 more bytes → no `upg_wen_o` pulses; `upg_adr_o` and `upg_dat_o` are unchanged.
